// File: rtl/fft_pkg.sv
// Shared types, default sizing and butterfly address generation for the in-place DIT FFT.
// The scheduler, butterfly wrapper and twiddle ROM all use the same addressing function.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ADDR_W_MAX = 12;

    localparam int LOG2_N   = 4;
    localparam int N        = 1 << LOG2_N;
    localparam int HALF_N   = N / 2;
    localparam int RD_LAT   = 1;
    localparam int BFLY_LAT = 2;
    localparam int D        = RD_LAT + BFLY_LAT;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr0;
        logic [ADDR_W_MAX-1:0] addr1;
        logic [ADDR_W_MAX-1:0] tw;
    } bfly_addr_t;

    // Butterfly k of stage s: legs span apart inside groups of 2*span, twiddle W_N^(pos << (log2_n-1-s)).
    function automatic bfly_addr_t bfly_addr(input int log2_n, input int s,
                                             input logic [ADDR_W_MAX-1:0] k);
        logic [ADDR_W_MAX-1:0] span;
        logic [ADDR_W_MAX-1:0] pos;
        logic [ADDR_W_MAX-1:0] grp;
        bfly_addr_t r;
        span    = ADDR_W_MAX'(1) << s;
        pos     = k & (span - ADDR_W_MAX'(1));
        grp     = k >> s;
        r.addr0 = (grp << (s + 1)) + pos;
        r.addr1 = r.addr0 + span;
        r.tw    = pos << (log2_n - 1 - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_wr_delay_line.sv
// Fixed-depth shift register that turns each read issue into its write-back DEPTH cycles later.
// flush cancels everything in flight, including the entry arriving on the same edge.
module fft_wr_delay_line #(
    parameter int DEPTH = 3,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr0,
    input  logic [AW-1:0] in_addr1,
    output logic          out_valid,
    output logic [AW-1:0] out_addr0,
    output logic [AW-1:0] out_addr1
);

    logic [DEPTH-1:0] v;
    logic [AW-1:0]    a0 [DEPTH];
    logic [AW-1:0]    a1 [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a0[i] <= '0;
                a1[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a0[i] <= '0;
                a1[i] <= '0;
            end
        end else begin
            v[0]  <= in_valid;
            a0[0] <= in_addr0;
            a1[0] <= in_addr1;
            for (int i = 1; i < DEPTH; i++) begin
                v[i]  <= v[i-1];
                a0[i] <= a0[i-1];
                a1[i] <= a1[i-1];
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_addr0 = a0[DEPTH-1];
    assign out_addr1 = a1[DEPTH-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Drives one shared radix-2 butterfly through all stages of an in-place DIT FFT,
// draining the datapath between stages so no stage reads ahead of the previous one's writes.
module fft_bfly_scheduler
    import fft_pkg::*;
#(
    parameter int LOG2_N   = 4,
    parameter int RD_LAT   = 1,
    parameter int BFLY_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(LOG2_N)-1:0] stage,
    output logic                      rd_en,
    output logic [LOG2_N-1:0]         rd_addr0,
    output logic [LOG2_N-1:0]         rd_addr1,
    output logic [LOG2_N-2:0]         tw_idx,
    output logic                      wr_en,
    output logic [LOG2_N-1:0]         wr_addr0,
    output logic [LOG2_N-1:0]         wr_addr1
);

    localparam int SW   = $clog2(LOG2_N);
    localparam int HALF = 1 << (LOG2_N - 1);
    localparam int DLY  = RD_LAT + BFLY_LAT;
    localparam int CW   = $clog2(DLY + 1);

    localparam logic [LOG2_N-1:0] K_LAST = LOG2_N'(HALF - 1);
    localparam logic [SW-1:0]     S_LAST = SW'(LOG2_N - 1);

    state_t            state;
    logic [LOG2_N-1:0] k;
    logic [CW-1:0]     cnt;

    logic [SW-1:0]     s_nx;
    logic [LOG2_N-1:0] k_nx;
    bfly_addr_t        a_nx;
    logic              unused_addr_bits;

    // Address of the butterfly that will be on the read port in the cycle after this edge.
    always_comb begin
        s_nx = stage;
        k_nx = k + LOG2_N'(1);
        case (state)
            IDLE: begin
                s_nx = '0;
                k_nx = '0;
            end
            DRAIN: begin
                s_nx = stage + SW'(1);
                k_nx = '0;
            end
            default: ;
        endcase
        a_nx = bfly_addr(LOG2_N, int'(s_nx), ADDR_W_MAX'(k_nx));
    end

    assign unused_addr_bits = ^a_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            stage    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= ISSUE;
                        stage    <= '0;
                        k        <= '0;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr0 <= a_nx.addr0[LOG2_N-1:0];
                        rd_addr1 <= a_nx.addr1[LOG2_N-1:0];
                        tw_idx   <= a_nx.tw[LOG2_N-2:0];
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                    end else if (k == K_LAST) begin
                        state <= DRAIN;
                        cnt   <= CW'(DLY);
                        rd_en <= 1'b0;
                    end else begin
                        k        <= k_nx;
                        rd_en    <= 1'b1;
                        rd_addr0 <= a_nx.addr0[LOG2_N-1:0];
                        rd_addr1 <= a_nx.addr1[LOG2_N-1:0];
                        tw_idx   <= a_nx.tw[LOG2_N-2:0];
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(1)) begin
                        if (stage == S_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            stage    <= s_nx;
                            k        <= '0;
                            rd_en    <= 1'b1;
                            rd_addr0 <= a_nx.addr0[LOG2_N-1:0];
                            rd_addr1 <= a_nx.addr1[LOG2_N-1:0];
                            tw_idx   <= a_nx.tw[LOG2_N-2:0];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fft_wr_delay_line #(
        .DEPTH (DLY),
        .AW    (LOG2_N)
    ) u_wr_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (rd_en),
        .in_addr0  (rd_addr0),
        .in_addr1  (rd_addr1),
        .out_valid (wr_en),
        .out_addr0 (wr_addr0),
        .out_addr1 (wr_addr1)
    );

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Scoreboard bench for fft_bfly_scheduler at N=16: expected read/write events are queued
// when a transform is started and matched against the DUT strobes cycle by cycle.
module tb_fft_bfly_scheduler;

    localparam int L    = 4;
    localparam int N    = 16;
    localparam int HALF = 8;
    localparam int D    = 3;
    localparam int STEP = HALF + D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage;
    logic [3:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [2:0] tw_idx;

    typedef struct {
        int cyc;
        int a0;
        int a1;
        int tw;
        int s;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int busy_from = 1;
    int busy_to = 0;
    int done_at = -1;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_wr_cyc = -1;
    int prev_rd_cyc = -10;
    int hits[N];

    fft_bfly_scheduler #(.LOG2_N(L), .RD_LAT(1), .BFLY_LAT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_idx   (tw_idx),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Standard DIT loop nest: blocks of 2*span, butterfly p inside a block, twiddle W_(2span)^p.
    task automatic push_run(input int t0);
        ev_t e;
        int  span, k, rc;
        for (int s = 0; s < L; s++) begin
            span = 1 << s;
            for (int j = 0; j < N; j += 2 * span) begin
                for (int p = 0; p < span; p++) begin
                    k  = (j / (2 * span)) * span + p;
                    rc = t0 + 1 + s * STEP + k;
                    e  = '{rc, j + p, j + p + span, p * (N / (2 * span)), s};
                    rd_q.push_back(e);
                    e.cyc = rc + D;
                    wr_q.push_back(e);
                end
            end
        end
        busy_from   = t0 + 1;
        busy_to     = t0 + L * STEP;
        done_at     = t0 + L * STEP + 1;
        last_wr_cyc = -1;
        prev_rd_cyc = -10;
    endtask

    task automatic trunc(input int keep_to);
        ev_t tmp[$];
        foreach (rd_q[i]) if (rd_q[i].cyc <= keep_to) tmp.push_back(rd_q[i]);
        rd_q = tmp;
        tmp.delete();
        foreach (wr_q[i]) if (wr_q[i].cyc <= keep_to) tmp.push_back(wr_q[i]);
        wr_q = tmp;
        busy_to = keep_to;
        done_at = -1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_start(input int t0);
        goto(t0);
        start = 1'b1;
        push_run(t0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_stats();
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        foreach (hits[i]) hits[i] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_rd_en"}, int'(rd_en), 0);
        check_val({tag, "_wr_en"}, int'(wr_en), 0);
        check_val({tag, "_stage"}, int'(stage), 0);
        check_val({tag, "_addrs"}, int'({rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1}), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            ev_t e;
            check_val("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            check_val("done", int'(done), int'(cyc == done_at));
            if (done) done_cnt++;
            if (wr_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (wr_q.size() == 0) begin
                    check_val("wr_extra", int'(wr_en), 0);
                end else begin
                    e = wr_q.pop_front();
                    check_val("wr_cyc", cyc, e.cyc);
                    check_val("wr_addr0", int'(wr_addr0), e.a0);
                    check_val("wr_addr1", int'(wr_addr1), e.a1);
                end
            end
            if (rd_en) begin
                rd_cnt++;
                hits[rd_addr0]++;
                hits[rd_addr1]++;
                if (prev_rd_cyc != cyc - 1 && last_wr_cyc >= 0)
                    check_val("hazard_gap", cyc - last_wr_cyc, 1);
                prev_rd_cyc = cyc;
                if (rd_q.size() == 0) begin
                    check_val("rd_extra", int'(rd_en), 0);
                end else begin
                    e = rd_q.pop_front();
                    check_val("rd_cyc", cyc, e.cyc);
                    check_val("rd_addr0", int'(rd_addr0), e.a0);
                    check_val("rd_addr1", int'(rd_addr1), e.a1);
                    check_val("tw_idx", int'(tw_idx), e.tw);
                    check_val("rd_stage", int'(stage), e.s);
                end
            end
        end
    end

    initial begin
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full transform with an ignored start mid-run
        clear_stats();
        run_start(5);
        check_val("first_rd_en", int'(rd_en), 1);
        check_val("first_rd_a0", int'(rd_addr0), 0);
        check_val("first_rd_a1", int'(rd_addr1), 1);
        check_val("first_tw", int'(tw_idx), 0);
        goto(9);
        check_val("first_wr_en", int'(wr_en), 1);
        check_val("first_wr_a0", int'(wr_addr0), 0);
        check_val("first_wr_a1", int'(wr_addr1), 1);
        goto(20);
        check_val("s1k3_a0", int'(rd_addr0), 5);
        check_val("s1k3_a1", int'(rd_addr1), 7);
        check_val("s1k3_tw", int'(tw_idx), 4);
        check_val("s1k3_stage", int'(stage), 1);
        goto(25);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        goto(44);
        check_val("s3k5_a0", int'(rd_addr0), 5);
        check_val("s3k5_a1", int'(rd_addr1), 13);
        check_val("s3k5_tw", int'(tw_idx), 5);
        goto(50);
        check_val("done_pulse", int'(done), 1);
        check_val("done_busy", int'(busy), 0);
        goto(65);
        check_val("a_rd_left", rd_q.size(), 0);
        check_val("a_wr_left", wr_q.size(), 0);
        check_val("a_rd_cnt", rd_cnt, L * HALF);
        check_val("a_wr_cnt", wr_cnt, L * HALF);
        check_val("a_done_cnt", done_cnt, 1);
        check_val("a_stage_hold", int'(stage), L - 1);
        foreach (hits[i]) check_val("a_addr_hits", hits[i], L);

        // Abort in stage 0 at k=5, then restart
        clear_stats();
        run_start(70);
        goto(76);
        abort = 1'b1;
        trunc(76);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_wr_en", int'(wr_en), 0);
        run_start(80);
        check_val("restart_stage", int'(stage), 0);
        check_val("restart_a0", int'(rd_addr0), 0);
        goto(140);
        check_val("b_rd_left", rd_q.size(), 0);
        check_val("b_wr_left", wr_q.size(), 0);
        check_val("b_rd_cnt", rd_cnt, 6 + L * HALF);
        check_val("b_wr_cnt", wr_cnt, 3 + L * HALF);
        check_val("b_done_cnt", done_cnt, 1);

        // start and abort together in IDLE
        clear_stats();
        goto(141);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check_val("c_busy", int'(busy), 0);
        goto(150);
        check_val("c_rd_cnt", rd_cnt, 0);
        check_val("c_done_cnt", done_cnt, 0);

        // Async reset mid-transform
        clear_stats();
        run_start(155);
        goto(185);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        trunc(184);
        goto(188);
        rst_n = 1'b1;
        goto(215);
        check_val("d_rd_left", rd_q.size(), 0);
        check_val("d_wr_left", wr_q.size(), 0);
        check_val("d_rd_cnt", rd_cnt, 23);
        check_val("d_wr_cnt", wr_cnt, 20);
        check_val("d_done_cnt", done_cnt, 0);

        // Abort while in DONE: pulse still completes
        clear_stats();
        run_start(220);
        goto(265);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        goto(280);
        check_val("e_done_cnt", done_cnt, 1);
        check_val("e_rd_left", rd_q.size(), 0);
        check_val("e_wr_left", wr_q.size(), 0);
        check_val("e_wr_cnt", wr_cnt, L * HALF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_bfly_scheduler.md
Name: fft_bfly_scheduler

Overview:
- Sequences one shared radix-2 butterfly datapath through a full in-place DIT FFT of N = 2^LOG2_N points.
- Data memory is assumed already loaded in bit-reversed order.
- Per stage, issues one butterfly per cycle: read address pair plus twiddle index. Writes back the same address pair after a fixed datapath delay.
- Drains the pipeline between stages so stage s+1 never reads a location before stage s has written it.

Parameters:
- LOG2_N, 4, log2 of FFT size; N = 16 by default; legal range 2..12.
- RD_LAT, 1, cycles from rd_en to butterfly inputs valid (memory read latency).
- BFLY_LAT, 2, cycles from butterfly inputs to outputs valid.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse after the final write.
- stage  out  $clog2(LOG2_N)  current stage index s.
- rd_en  out  1  issue strobe.
- rd_addr0  out  LOG2_N  upper-leg read address.
- rd_addr1  out  LOG2_N  lower-leg read address.
- tw_idx  out  LOG2_N-1  twiddle ROM index, W_N^tw_idx; valid with rd_en.
- wr_en  out  1  write-back strobe.
- wr_addr0  out  LOG2_N  upper-leg write address.
- wr_addr1  out  LOG2_N  lower-leg write address.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; butterfly counter k, stage counter and delay line cleared.
- Constants: D = RD_LAT + BFLY_LAT (default 3).
- Addressing, registered outputs valid in the same cycle as rd_en:
  - span = 2^s; pos = k & (span-1); grp = k >> s.
  - rd_addr0 = grp*2*span + pos; rd_addr1 = rd_addr0 + span.
  - tw_idx = pos << (LOG2_N-1-s).
  - All arithmetic is unsigned, LOG2_N bits, with no overflow for legal k.
- State machine:
  - IDLE: start=1 -> ISSUE with s=0, k=0. Otherwise stay.
  - ISSUE: rd_en=1 every cycle; k increments.
    - k = N/2-1 -> DRAIN, drain counter loaded with D.
  - DRAIN: rd_en=0; counter decrements each cycle.
    - Counter reaches 1 with s < LOG2_N-1 -> ISSUE, s+1, k=0.
    - Counter reaches 1 with s = LOG2_N-1 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. busy=0 in this cycle.
- Write-back:
  - wr_en and wr_addr0/1 equal rd_en and rd_addr0/1 delayed exactly D cycles, via a shift register.
  - The last write of each stage lands in the last DRAIN cycle. The next stage's first read follows on the next cycle; there is no read-before-write hazard.
- Timing for N=16, D=3, start high at cycle 0:
  - Each stage takes 8 issue + 3 drain = 11 cycles.
  - busy is high in cycles 1..44; done is high at cycle 45.
  - Total is LOG2_N*(N/2+D)+1 cycles from start to done.
- Boundary conditions:
  - start while busy or in DONE: ignored, no restart.
  - start and abort in the same cycle in IDLE: abort wins; stay IDLE.
  - abort in ISSUE/DRAIN: next cycle IDLE; busy=0; delay line flushed, so no further wr_en; done not asserted.
  - abort in DONE: done pulse still completes. No later write is pending at that point.
  - rst_n mid-transform: immediate clear as for reset, with no partial writes afterwards.
  - stage holds its last value in DONE. It returns to 0 on the next accepted start.

Decomposition:
- Shared package fft_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE).
  - Derived constants N, HALF_N, D.
  - Address-generation function: (s, k) -> addr0, addr1, tw_idx.
  - The butterfly wrapper and twiddle ROM reuse the same function and constants.
- One sub-module, fft_wr_delay_line: parameterised depth D, carries {valid, addr0, addr1}, async reset, synchronous flush input driven by abort.

Test Plan:
- Reset then start at cycle 0 (N=16) -> first rd_en at cycle 1 with addr0=0, addr1=1, tw_idx=0; first wr_en at cycle 4 with addr0=0, addr1=1.
- Stage 1, k=3 -> rd_addr0=5, rd_addr1=7, tw_idx=4. Stage 3, k=5 -> rd_addr0=5, rd_addr1=13, tw_idx=5.
- Full run, N=16 -> exactly 32 rd_en and 32 wr_en pulses; busy high cycles 1..44; done pulse at cycle 45 only. Every address 0..15 is read twice per stage pair.
- Hazard check -> for every stage, last wr_en cycle < first rd_en cycle of the next stage. Gap is exactly 1 cycle with default D=3.
- abort at cycle 6 (stage 0, k=5) -> busy=0 at cycle 7. No wr_en at cycle 7 or later. done never asserted. A start at cycle 10 restarts from s=0, k=0.
- start pulsed at cycle 20 during busy -> ignored; done still at cycle 45. Async rst_n low at cycle 30 -> all outputs 0 immediately, IDLE.
